// File: rtl/com_bus_arbiter.sv
// Round-robin owner arbiter for the shared coherence bus, with a dead turnaround cycle between tenures.
// Optional tenure limit enabled by defining COM_BUS_TIMEOUT_EN.
module com_bus_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int ID_W       = 3,
    parameter int MAX_TENURE = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] Com_Bus_Req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt,
    output logic [ID_W-1:0]    Gnt_id,
    output logic               Bus_busy,
    output logic               Timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) ||
        MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_param_check
        $error("com_bus_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [ID_W-1:0] rr_ptr, rr_nxt;
    logic [ID_W-1:0] owner_inc;
    logic            req_found;
    logic [ID_W-1:0] req_sel;
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_sel, lo_sel;
    logic            tenure_max;

    // Lowest set bit at or above rr_ptr wins; otherwise lowest set bit below it (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Com_Bus_Req[i]) begin
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_sel   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = ID_W'(i);
                end
            end
        end
        req_found = hi_found | lo_found;
        req_sel   = hi_found ? hi_sel : lo_sel;
    end

    assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE, TURN: begin
                if (req_found) begin
                    state_nxt = GRANT;
                    owner_nxt = req_sel;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!Com_Bus_Req[owner] || tenure_max) begin
                    state_nxt = TURN;
                    rr_nxt    = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears the grant without a clock.
    always_comb begin
        Com_Bus_Gnt = '0;
        if (state == GRANT) Com_Bus_Gnt[owner] = 1'b1;
        Bus_busy = (state == GRANT);
        Gnt_id   = owner;
    end

`ifdef COM_BUS_TIMEOUT_EN
    logic [7:0] tenure;
    logic       timeout_q;

    assign tenure_max = (tenure == 8'(MAX_TENURE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tenure    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == GRANT) && Com_Bus_Req[owner] && tenure_max;
            if (state != GRANT && state_nxt == GRANT) tenure <= '0;
            else if (state == GRANT)                  tenure <= tenure + 8'd1;
        end
    end

    assign Timeout_err = timeout_q;
`else
    assign tenure_max  = 1'b0;
    assign Timeout_err = 1'b0;
`endif

endmodule

// File: doc/com_bus_arbiter.md
Name: com_bus_arbiter

Overview:
- Round-robin arbiter for the shared coherence bus (Address_Com / Data_Bus_Com / Data_in_Bus) in the 4-core MESI system.
- Sits directly downstream of every per-core cache wrapper: 4 cores × I/D caches give 8 requesters.
- Consumes each cache's Com_Bus_Req_proc and returns the matching Com_Bus_Gnt_proc.
- Guarantees exactly one bus owner at a time, fair rotation among requesters, and a dead cycle between tenures.

Parameters:
- NUM_REQ, 8, number of requesting caches; legal range 2..16.
- ID_W, 3, width of Gnt_id; must equal clog2(NUM_REQ).
- MAX_TENURE, 64, maximum grant length in cycles (used only with COM_BUS_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Com_Bus_Req  input  NUM_REQ  level request, bit i from cache i (its Com_Bus_Req_proc).
- Com_Bus_Gnt  output  NUM_REQ  one-hot-or-zero grant, bit i to cache i (its Com_Bus_Gnt_proc).
- Gnt_id  output  ID_W  binary index of the current owner.
- Bus_busy  output  1  high while a grant is active.
- Timeout_err  output  1  one-cycle pulse when a tenure is forcibly revoked.

Behaviour:
- Reset and clocking: one clock (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: Com_Bus_Gnt=0, Gnt_id=0, Bus_busy=0, Timeout_err=0, rr_ptr=0, state=IDLE, tenure counter=0.
- Reset mid-tenure: grant drops immediately (asynchronously). The owner's in-flight bus transaction is abandoned; requesters must re-request after reset.
- All outputs are registered; no combinational path from Com_Bus_Req to any output.
- State IDLE:
  - If any Com_Bus_Req bit is high, select the first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Next cycle: Com_Bus_Gnt[sel]=1, Gnt_id=sel, Bus_busy=1, state=GRANT.
  - Latency: request sampled at edge n gives grant visible after edge n.
  - If no request, stay in IDLE.
- State GRANT:
  - Grant is held while Com_Bus_Req[owner] stays high. Requests from other caches are ignored for preemption.
  - When Com_Bus_Req[owner] is sampled low: Com_Bus_Gnt=0, Bus_busy=0, rr_ptr=(owner+1) mod NUM_REQ, state=TURN.
- State TURN:
  - Exactly one dead cycle for bus turnaround; no grant is asserted.
  - Arbitrates with the updated rr_ptr exactly as IDLE does: go to GRANT if a request is present, else go to IDLE.
  - Back-to-back tenures: owner drops its request at edge n, the bus is idle during cycle n+1, the next grant is asserted from edge n+2.
- Request protocol: requests are level-sensitive and not latched. A request dropped before it is granted is lost without error.
- Owner freedom: the owner may re-request immediately after release. It then ranks last in the rotation because rr_ptr has moved past it.
- Simultaneous requests: rr_ptr alone decides. After a release, the releasing requester has the lowest priority.
- Wrap-around: owner NUM_REQ-1 releases -> rr_ptr=0.
- Invariant: popcount(Com_Bus_Gnt) <= 1 in every cycle. Bus_busy == |Com_Bus_Gnt.
- Gnt_id holds its last value while Bus_busy=0; it is valid only while Bus_busy=1.

Optional Feature:
- Macro: COM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit tenure counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches MAX_TENURE-1 with the owner's request still high, the grant is revoked on the next edge. Timeout_err pulses for 1 cycle, rr_ptr advances past the owner, and state goes to TURN.
  - The owner's still-high request competes again normally, at lowest priority.
- Undefined:
  - No counter is synthesised and tenure is unbounded.
  - Timeout_err is tied to 0 and MAX_TENURE is ignored.

Test Plan:
- Reset, then Com_Bus_Req=8'h00 for 10 cycles -> Com_Bus_Gnt=0, Bus_busy=0, Gnt_id=0 throughout.
- Com_Bus_Req=8'h04 held 5 cycles, then 0 -> Com_Bus_Gnt=8'h04 and Gnt_id=2 one cycle after request; grant held 5 cycles; rr_ptr becomes 3 (observed via the next arbitration).
- Com_Bus_Req=8'hFF held continuously, each owner dropping its bit for 1 cycle after a 3-cycle tenure -> grants in order 0,1,...,7,0, with exactly 1 idle cycle between tenures and never two grant bits set.
- Owner 7 releases while requests 0 and 6 are pending -> next grant goes to 0 (wrap-around), then 6.
- rst_n pulsed low mid-tenure with Com_Bus_Gnt=8'h10 -> Com_Bus_Gnt=0 and Bus_busy=0 immediately, without waiting for clk; after release the first grant searches from index 0.
- With COM_BUS_TIMEOUT_EN, MAX_TENURE=4: Com_Bus_Req=8'h03 held -> requester 0 granted 4 cycles, 1-cycle Timeout_err pulse, TURN, requester 1 granted. Without the macro, requester 0 keeps the grant indefinitely and Timeout_err stays 0.
